// File: rtl/key_input_ctrl.sv
// Front-panel input conditioner: synchronises and debounces keys and switches, emits key
// rise pulses and drives a run/pause/single-step CPU clock enable.
module key_input_ctrl #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned SW_W      = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            key_go,
    input  logic            key_run,
    input  logic            key_step,
    input  logic [SW_W-1:0] sw_in,
    output logic            go_level,
    output logic            go_pulse,
    output logic [SW_W-1:0] sw_out,
    output logic            cpu_en,
    output logic [1:0]      mode
);

    localparam int unsigned NumCh  = SW_W + 3;
    localparam logic [23:0] CntMax = 24'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || DB_CYCLES > 32'd16_777_215) begin : g_bad_db_cycles
        $error("key_input_ctrl: DB_CYCLES must be within 2 .. 2^24-1");
    end

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StPause = 2'b01,
        StStep  = 2'b10
    } mode_e;

    // Channel order: bit 0 go, bit 1 run, bit 2 step, bits 3.. switches.
    logic [NumCh-1:0] raw;
    logic [NumCh-1:0] s1_q, s2_q;
    logic [NumCh-1:0] st_q, st_d;
    logic [23:0]      cnt_q [NumCh];
    logic [23:0]      cnt_d [NumCh];
    logic [2:0]       key_dly_q;
    logic [2:0]       pulse_q, pulse_d;
    mode_e            mode_q, mode_d;
    logic             run_p, step_p;

    assign raw    = {sw_in, key_step, key_run, key_go};
    assign run_p  = pulse_q[1];
    assign step_p = pulse_q[2];

    // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < int'(NumCh); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 24'd1;
                end
            end
        end
        pulse_d = st_q[2:0] & ~key_dly_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q      <= '0;
            s2_q      <= '0;
            st_q      <= '0;
            key_dly_q <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < int'(NumCh); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            st_q      <= st_d;
            key_dly_q <= st_q[2:0];
            pulse_q   <= pulse_d;
            for (int i = 0; i < int'(NumCh); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mode_q <= StRun;
        end else begin
            mode_q <= mode_d;
        end
    end

    // run_p has priority over step_p in PAUSE; pulses arriving during STEP are dropped.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            StRun:   if (run_p) mode_d = StPause;
            StPause: begin
                if (run_p) begin
                    mode_d = StRun;
                end else if (step_p) begin
                    mode_d = StStep;
                end
            end
            StStep:  mode_d = StPause;
            default: mode_d = StRun;
        endcase
    end

    always_comb begin
        cpu_en   = (mode_q == StRun) || (mode_q == StStep);
        mode     = mode_q;
        go_level = st_q[0];
        go_pulse = pulse_q[0];
        sw_out   = st_q[NumCh-1:3];
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Bench for key_input_ctrl: sliding-window debounce model checked every cycle, plus
// hand-computed literal expectations along the directed sequence.
module tb_key_input_ctrl;

    localparam int DB  = 4;
    localparam int SW  = 5;
    localparam int NCH = SW + 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          key_go, key_run, key_step;
    logic [SW-1:0] sw_in;
    logic          go_level, go_pulse, cpu_en;
    logic [SW-1:0] sw_out;
    logic [1:0]    mode;

    int total = 0;
    int bad = 0;
    int pulse_seen = 0;

    key_input_ctrl #(
        .DB_CYCLES(DB),
        .SW_W     (SW)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .key_go  (key_go),
        .key_run (key_run),
        .key_step(key_step),
        .sw_in   (sw_in),
        .go_level(go_level),
        .go_pulse(go_pulse),
        .sw_out  (sw_out),
        .cpu_en  (cpu_en),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    // Model: a level flips once the last DB synchronised samples all disagree with it.
    logic [NCH-1:0] hist [$];
    logic [NCH-1:0] m_st, m_st_old, raw_now;
    logic [2:0]     m_pulse;
    int             m_mode;
    bit             m_valid = 0;

    always @(posedge clk) begin
        raw_now = {sw_in, key_step, key_run, key_go};
        if (clr) begin
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_back('0);
            m_st = '0;
            m_st_old = '0;
            m_pulse = '0;
            m_mode = 0;
            m_valid = 1;
        end else if (m_valid) begin
            case (m_mode)
                0: if (m_pulse[1]) m_mode = 1;
                1: begin
                    if (m_pulse[1]) m_mode = 0;
                    else if (m_pulse[2]) m_mode = 2;
                end
                default: m_mode = 1;
            endcase
            m_pulse = m_st[2:0] & ~m_st_old[2:0];
            m_st_old = m_st;
            hist.push_back(raw_now);
            if (hist.size() > DB + 2) void'(hist.pop_front());
            for (int ch = 0; ch < NCH; ch++) begin
                bit all_diff;
                all_diff = 1;
                for (int j = 0; j < DB; j++) begin
                    if (hist[hist.size() - 3 - j][ch] == m_st[ch]) all_diff = 0;
                end
                if (all_diff) m_st[ch] = ~m_st[ch];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (go_pulse === 1'b1) pulse_seen++;
        if (m_valid) begin
            chk("model_go_level", {31'd0, go_level}, {31'd0, m_st[0]});
            chk("model_go_pulse", {31'd0, go_pulse}, {31'd0, m_pulse[0]});
            chk("model_sw_out", {27'd0, sw_out}, {27'd0, m_st[NCH-1:3]});
            chk("model_mode", {30'd0, mode}, 32'(m_mode));
            chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, m_mode != 1});
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    initial begin
        clr = 1'b1;
        key_go = 1'b0;
        key_run = 1'b0;
        key_step = 1'b0;
        sw_in = '0;
        tick(2);
        clr = 1'b0;
        chk("reset_mode", {30'd0, mode}, 32'd0);
        chk("reset_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("reset_sw_out", {27'd0, sw_out}, 32'd0);
        chk("reset_go_level", {31'd0, go_level}, 32'd0);

        // Clean Go press and release
        key_go = 1'b1;
        tick(5);  chk("t1_level_e5", {31'd0, go_level}, 32'd0);
        tick(1);  chk("t1_level_e6", {31'd0, go_level}, 32'd1);
        chk("t1_pulse_e6", {31'd0, go_pulse}, 32'd0);
        tick(1);  chk("t1_pulse_e7", {31'd0, go_pulse}, 32'd1);
        tick(1);  chk("t1_pulse_e8", {31'd0, go_pulse}, 32'd0);
        tick(10); chk("t1_held_pulse", {31'd0, go_pulse}, 32'd0);
        pulse_seen = 0;
        key_go = 1'b0;
        tick(5);  chk("t1_rel_e5", {31'd0, go_level}, 32'd1);
        tick(1);  chk("t1_rel_e6", {31'd0, go_level}, 32'd0);
        tick(4);  chk("t1_rel_no_pulse", 32'(pulse_seen), 32'd0);

        // Bouncing Go
        pulse_seen = 0;
        key_go = 1'b1; tick(2);
        key_go = 1'b0; tick(2);
        key_go = 1'b1; tick(2);
        key_go = 1'b0; tick(2);
        chk("t2_bounce_level", {31'd0, go_level}, 32'd0);
        key_go = 1'b1;
        tick(5);  chk("t2_level_e5", {31'd0, go_level}, 32'd0);
        tick(1);  chk("t2_level_e6", {31'd0, go_level}, 32'd1);
        tick(10); chk("t2_one_pulse", 32'(pulse_seen), 32'd1);
        key_go = 1'b0;
        tick(10);

        // Mode FSM
        key_run = 1'b1;
        tick(7);  chk("t3_run_e7", {30'd0, mode}, 32'd0);
        tick(1);  chk("t3_pause", {30'd0, mode}, 32'd1);
        chk("t3_pause_en", {31'd0, cpu_en}, 32'd0);
        key_run = 1'b0; tick(10);
        key_step = 1'b1;
        tick(8);  chk("t3_step", {30'd0, mode}, 32'd2);
        chk("t3_step_en", {31'd0, cpu_en}, 32'd1);
        tick(1);  chk("t3_step_back", {30'd0, mode}, 32'd1);
        chk("t3_step_back_en", {31'd0, cpu_en}, 32'd0);
        key_step = 1'b0; tick(10);
        key_run = 1'b1;
        tick(8);  chk("t3_resume", {30'd0, mode}, 32'd0);
        key_run = 1'b0; tick(10);
        key_step = 1'b1;
        tick(12); chk("t3_step_in_run", {30'd0, mode}, 32'd0);
        key_step = 1'b0; tick(10);

        // Simultaneous run and step while paused
        key_run = 1'b1;
        tick(8);  chk("t4_pause", {30'd0, mode}, 32'd1);
        key_run = 1'b0; tick(10);
        key_run = 1'b1;
        key_step = 1'b1;
        tick(8);  chk("t4_run_wins", {30'd0, mode}, 32'd0);
        tick(4);  chk("t4_still_run", {30'd0, mode}, 32'd0);
        key_run = 1'b0;
        key_step = 1'b0;
        tick(10);

        // Switches
        sw_in = 5'b10110;
        tick(5);  chk("t5_sw_e5", {27'd0, sw_out}, 32'd0);
        tick(1);  chk("t5_sw_e6", {27'd0, sw_out}, 32'h16);
        tick(4);
        sw_in = 5'b10111; tick(3);
        sw_in = 5'b10110;
        tick(10); chk("t5_glitch", {27'd0, sw_out}, 32'h16);

        // Reset mid-operation
        key_run = 1'b1;
        tick(8);  chk("t6_pause", {30'd0, mode}, 32'd1);
        key_run = 1'b0; tick(10);
        key_go = 1'b1;
        tick(4);
        clr = 1'b1;
        tick(1);
        chk("t6_mode", {30'd0, mode}, 32'd0);
        chk("t6_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("t6_sw_out", {27'd0, sw_out}, 32'd0);
        chk("t6_go_level", {31'd0, go_level}, 32'd0);
        chk("t6_go_pulse", {31'd0, go_pulse}, 32'd0);
        clr = 1'b0;
        tick(5);  chk("t6_restart_e5", {31'd0, go_level}, 32'd0);
        tick(1);  chk("t6_restart_e6", {31'd0, go_level}, 32'd1);
        chk("t6_sw_back", {27'd0, sw_out}, 32'h16);
        tick(1);  chk("t6_pulse_e7", {31'd0, go_pulse}, 32'd1);
        key_go = 1'b0;
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
